seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed seven-segment display driver for the four-digit board display, running entirely in the `mclk` domain. An internal prescaler produces a single-cycle refresh strobe, so no derived clock is used. The block latches a frame of display data at each frame boundary and cycles the anodes through the digits. It applies leading-zero blanking and a ghosting guard interval, and drives active-low anode, segment and decimal-point pins.

## Interface
- `DIGITS`, 4: number of multiplexed digits; fixed at 4 for this board.
- `TICK_DIV`, 32768: `mclk` cycles per digit slot; 1525.9 Hz slot rate at 50 MHz. Minimum 2.
- `GUARD`, 64: cycles with all anodes off after each digit advance. Must be less than `TICK_DIV`; 0 disables the guard.
- `mclk`, in, 1: master clock.
- `clr`, in, 1: reset, synchronous, active-high.
- `value`, in, 16: hex digits; digit k = `value[4k+3:4k]`; digit 0 is rightmost.
- `dp`, in, 4: decimal point per digit, active-high.
- `digit_en`, in, 4: per-digit enable; 0 blanks that digit.
- `lzb`, in, 1: leading-zero blanking enable.
- `an`, out, 4: anodes, active-low; `an[k]` selects digit k.
- `seg`, out, 7: segments, active-low, packed as `{g,f,e,d,c,b,a}`.
- `dp_n`, out, 1: decimal point, active-low.
- `scan_tick`, out, 1: one-cycle pulse on each digit advance.

## Operation
- **Prescaler `cnt`:** counts 0 to `TICK_DIV-1`, then wraps to 0.
  - On the terminal edge, `idx` increments modulo `DIGITS` (3 wraps to 0).
  - On the same edge, `scan_tick` is registered high for one cycle and `gcnt` is loaded with `GUARD`.
- **Guard counter `gcnt`:** decrements to 0 and holds there.
- **Shadow registers:** `value`, `dp`, `digit_en` and `lzb` are captured at each frame start. A frame start is either:
  - the first cycle after `clr` deasserts (a pending flag is set by reset), or
  - the edge where `idx` wraps from `DIGITS-1` to 0.
  - Between frame starts, input changes have no visible effect, so each frame is displayed consistently.
- **Digit k blanked:** digit k is blanked when `digit_en_s[k]` is 0, OR when all of the following hold:
  - `lzb_s` is 1,
  - k is not 0,
  - every nibble from k up to `DIGITS-1` is 0.
  - Digit 0 is never blanked by `lzb`.
- **Output register (one `mclk` of lag after state):**
  - `an`: all ones if `gcnt` is not 0 or the current digit is blanked; otherwise one-cold at `idx`.
  - `seg`: the hex decode of the current nibble, or `7'b1111111` when the digit is blanked.
  - `dp_n`: `~dp_s[idx]`, forced to 1 when the digit is blanked.
- **Hex decode, active-low `{g..a}`:**

  | Digit | Code | Digit | Code |
  |---|---|---|---|
  | 0 | 1000000 | 8 | 0000000 |
  | 1 | 1111001 | 9 | 0010000 |
  | 2 | 0100100 | A | 0001000 |
  | 3 | 0110000 | b | 0000011 |
  | 4 | 0011001 | C | 1000110 |
  | 5 | 0010010 | d | 0100001 |
  | 6 | 0000010 | E | 0000110 |
  | 7 | 1111000 | F | 0001110 |

- **Reset values:**
  - `cnt`=0, `idx`=0, `gcnt`=0.
  - Shadow registers = 0.
  - `an`=1111, `seg`=1111111, `dp_n`=1, `scan_tick`=0.
- **`clr` mid-frame:** all of the above take effect on the next edge. The display goes dark immediately and the frame is recaptured on the cycle after release.

## Timing
- `scan_tick` period is exactly `TICK_DIV` cycles. The first pulse is registered on the `TICK_DIV`th edge after `clr` deasserts.
- After each advance edge, `an` is 1111 for `GUARD` cycles, then selects the new digit. With `GUARD`=0, the new digit appears one cycle after the advance.
- Full frame = `DIGITS*TICK_DIV` cycles; the default is 131072 cycles, about 381 Hz at 50 MHz.
- Input to display latency is at most one frame plus 2 cycles.
- At most one anode is low on any cycle.

## Structure
- Shared package `seg7_pkg`:
  - active-low segment pattern constants for 0–F,
  - `SEG_BLANK` = 7'h7F,
  - `AN_OFF` = 4'hF.
- Sub-module `hex7seg`: purely combinational 4-bit to 7-bit decoder, reused by other display blocks.
- `seg7_scan` holds the prescaler, digit index, guard counter, shadow registers, blanking logic and the output register.

## Test plan
Benches use `TICK_DIV`=4 and `GUARD`=1 unless noted.
- **Basic scan:** `value`=16'h12AF, all enabled, `lzb`=0 → `an` sequence 1110/1101/1011/0111 with `seg` 0001110/0001000/0100100/1111001. `an`=1111 for 1 cycle after each `scan_tick`; `scan_tick` every 4 cycles.
- **Leading-zero blanking:** `value`=16'h0005, `lzb`=1 → only digit 0 lit, `seg`=0010010; the digit 1–3 slots show `an`=1111. `value`=16'h0000 → digit 0 shows 1000000. `value`=16'h0305 → digit 1 shows 0 (1000000).
- **Frame capture:** change `value` from 16'h1111 to 16'h2222 during the `idx`=1 slot → digits 2 and 3 still show 1111001 this frame; all digits show 0100100 from the next frame.
- **Enable and decimal point:** `digit_en`=4'b1010, `dp`=4'b0010 → digits 0 and 2 dark with `dp_n`=1; digit 1 shows `dp_n`=0; digit 3 shows `dp_n`=1.
- **Mid-frame reset:** assert `clr` during the `idx`=2 slot → next edge `an`=1111, `seg`=1111111, `scan_tick`=0. After release, the first `scan_tick` arrives 4 cycles later and digit 1 is selected.
- **Guard disabled:** `GUARD`=0, `TICK_DIV`=2 → no all-off cycles; each digit is held for exactly 2 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a}
// glyph patterns for hex digits plus the all-off codes.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder,
// shared by the board's display blocks.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with frame-latched
// data, leading-zero blanking and an anode guard after each advance.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 32768,
    parameter int GUARD    = 64
) (
    input  logic                  mclk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lzb,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic                  scan_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         gcnt;
    logic [IW-1:0]         idx;
    logic                  pend;
    logic [4*DIGITS-1:0]   value_s;
    logic [DIGITS-1:0]     dp_s;
    logic [DIGITS-1:0]     en_s;
    logic                  lzb_s;

    logic [DIGITS-1:0]     blank;
    logic                  term;
    logic                  last;
    logic                  cur_blank;
    logic [3:0]            nib;
    logic [6:0]            dec;

    assign term      = (cnt == CW'(TICK_DIV - 1));
    assign last      = (idx == IW'(DIGITS - 1));
    assign nib       = value_s[4*idx +: 4];
    assign cur_blank = blank[idx];

    // A digit is dark if disabled, or if it and every digit above it are zero
    always_comb begin
        blank = '0;
        for (int k = 0; k < DIGITS; k++) begin
            blank[k] = !en_s[k]
                || (lzb_s && (k != 0)
                    && ((value_s >> (4*k)) == '0));
        end
    end

    hex7seg u_dec (
        .nib (nib),
        .seg (dec)
    );

    always_ff @(posedge mclk) begin
        if (clr) begin
            cnt       <= '0;
            idx       <= '0;
            gcnt      <= '0;
            pend      <= 1'b1;
            value_s   <= '0;
            dp_s      <= '0;
            en_s      <= '0;
            lzb_s     <= 1'b0;
            an        <= AN_OFF;
            seg       <= SEG_BLANK;
            dp_n      <= 1'b1;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= 1'b0;
            if (gcnt != '0) begin
                gcnt <= gcnt - 1'b1;
            end
            if (term) begin
                cnt       <= '0;
                idx       <= last ? '0 : idx + 1'b1;
                scan_tick <= 1'b1;
                gcnt      <= CW'(GUARD);
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Latch a whole frame at once so a frame never tears
            if (pend || (term && last)) begin
                pend    <= 1'b0;
                value_s <= value;
                dp_s    <= dp;
                en_s    <= digit_en;
                lzb_s   <= lzb;
            end
            an   <= ((gcnt != '0) || cur_blank)
                    ? AN_OFF : ~(DIGITS'(1) << idx);
            seg  <= cur_blank ? SEG_BLANK : dec;
            dp_n <= cur_blank | ~dp_s[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (guarded and unguarded) compared
// every cycle against a cycle-count based reference model.
module tb_seg7_scan;

    localparam int TA = 4;
    localparam int GA = 1;
    localparam int TB = 2;
    localparam int GB = 0;

    logic        mclk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  digit_en = '0;
    logic        lzb = 1'b0;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dpn_a, dpn_b;
    logic       tick_a, tick_b;

    int errors = 0;
    int checks = 0;

    always #5 mclk = ~mclk;

    seg7_scan #(.DIGITS(4), .TICK_DIV(TA), .GUARD(GA)) dut_a (
        .mclk      (mclk),
        .clr       (clr),
        .value     (value),
        .dp        (dp),
        .digit_en  (digit_en),
        .lzb       (lzb),
        .an        (an_a),
        .seg       (seg_a),
        .dp_n      (dpn_a),
        .scan_tick (tick_a)
    );

    seg7_scan #(.DIGITS(4), .TICK_DIV(TB), .GUARD(GB)) dut_b (
        .mclk      (mclk),
        .clr       (clr),
        .value     (value),
        .dp        (dp),
        .digit_en  (digit_en),
        .lzb       (lzb),
        .an        (an_b),
        .seg       (seg_b),
        .dp_n      (dpn_b),
        .scan_tick (tick_b)
    );

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // m = edges since release; shadow copy and expected outputs
    typedef struct {
        int         m;
        logic       pend;
        logic [15:0] v;
        logic [3:0] d;
        logic [3:0] e;
        logic       z;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        logic       tick;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t advance(mdl_t s, int T, int G);
        mdl_t r;
        int   k;
        int   off;
        int   g;
        logic bl;
        r = s;
        if (clr) begin
            r.m = 0; r.pend = 1'b1;
            r.v = '0; r.d = '0; r.e = '0; r.z = 1'b0;
            r.an = 4'hF; r.seg = 7'h7F;
            r.dpn = 1'b1; r.tick = 1'b0;
            return r;
        end
        k   = (s.m / T) % 4;
        off = s.m % T;
        g   = (s.m >= T && off < G) ? G - off : 0;
        bl  = !s.e[k]
            || (s.z && k != 0 && (s.v >> (4*k)) == 16'h0);
        r.an  = (g != 0 || bl) ? 4'hF : ~(4'b0001 << k);
        r.seg = bl ? 7'h7F : hex_tab[s.v[4*k +: 4]];
        r.dpn = bl ? 1'b1 : ~s.d[k];
        r.m    = s.m + 1;
        r.tick = (r.m % T) == 0;
        if (s.pend || (r.m % (4*T)) == 0) begin
            r.pend = 1'b0;
            r.v = value; r.d = dp;
            r.e = digit_en; r.z = lzb;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [6:0] got,
                       logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b t=%0t",
                   tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        ma = advance(ma, TA, GA);
        mb = advance(mb, TB, GB);
        #1;
        chk("an_a",   {3'b0, an_a},   {3'b0, ma.an});
        chk("seg_a",  seg_a,          ma.seg);
        chk("dpn_a",  {6'b0, dpn_a},  {6'b0, ma.dpn});
        chk("tick_a", {6'b0, tick_a}, {6'b0, ma.tick});
        chk("an_b",   {3'b0, an_b},   {3'b0, mb.an});
        chk("seg_b",  seg_b,          mb.seg);
        chk("dpn_b",  {6'b0, dpn_b},  {6'b0, mb.dpn});
        chk("tick_b", {6'b0, tick_b}, {6'b0, mb.tick});
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idx_a(int k);
        for (int i = 0; i < 4*TA && ((ma.m / TA) % 4) != k; i++)
            step();
    endtask

    initial begin
        ma = '{m: 0, pend: 1'b1, v: '0, d: '0, e: '0, z: 1'b0,
               an: 4'hF, seg: 7'h7F, dpn: 1'b1, tick: 1'b0};
        mb = ma;

        run(3);

        value = 16'h12AF; digit_en = 4'hF; dp = 4'h0; lzb = 1'b0;
        clr = 1'b0;
        run(36);

        value = 16'h0005; lzb = 1'b1;
        run(36);
        value = 16'h0000;
        run(32);
        value = 16'h0305;
        run(32);

        value = 16'h1111; lzb = 1'b0;
        run(20);
        wait_idx_a(1);
        value = 16'h2222;
        run(36);

        digit_en = 4'b1010; dp = 4'b0010;
        run(36);

        digit_en = 4'hF; dp = 4'b0101; value = 16'h9876;
        run(18);
        wait_idx_a(2);
        clr = 1'b1;
        run(2);
        clr = 1'b0;
        run(40);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                value = ($urandom_range(0, 2) == 0)
                    ? 16'($urandom_range(0, 255))
                    : 16'($urandom);
                dp       = 4'($urandom);
                digit_en = ($urandom_range(0, 1) == 0)
                    ? 4'hF : 4'($urandom);
                lzb      = 1'($urandom);
            end
            clr = ($urandom_range(0, 79) == 0);
            step();
        end
        clr = 1'b0;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
